// File: rtl/neuron_mac_engine.sv
// Dot-product engine for the SRAM-backed neural network: two signed MACs per cycle,
// one saturated sum per output neuron, and the arg-max class after the last neuron.
module neuron_mac_engine #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_OUTPUTS = 10,
    parameter int ACC_WIDTH   = 48
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    output logic [11:0]        weight_address,
    input  logic [31:0]        weight_value,
    output logic [9:0]         pixel_address1,
    output logic [9:0]         pixel_address2,
    input  logic [15:0]        pixel_value1,
    input  logic [15:0]        pixel_value2,
    output logic               busy,
    output logic               sum_valid,
    output logic [3:0]         neuron_index,
    output logic signed [31:0] neuron_sum,
    output logic               done,
    output logic [3:0]         class_out
);

    localparam int PAIRS = NUM_INPUTS / 2;
    localparam logic [9:0] LAST_PAIR   = 10'(PAIRS - 1);
    localparam logic [3:0] LAST_NEURON = 4'(NUM_OUTPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sh7FFF_FFFF);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN1,
        S_DRAIN2,
        S_EMIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [11:0]                 r_waddr;
    logic [9:0]                  r_pair;
    logic [3:0]                  r_neuron;
    logic                        w_vld_p0;
    logic                        r_vld_p1;
    logic                        r_vld_p2;
    logic signed [16:0]          w_pix0_p1;
    logic signed [16:0]          w_pix1_p1;
    logic signed [15:0]          w_wt0_p1;
    logic signed [15:0]          w_wt1_p1;
    logic signed [32:0]          w_prod0_p1;
    logic signed [32:0]          w_prod1_p1;
    logic signed [32:0]          r_prod0_p2;
    logic signed [32:0]          r_prod1_p2;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        w_clear;
    logic signed [31:0]          w_sum_sat;
    logic signed [31:0]          r_max_sum;
    logic [3:0]                  r_class;

    function automatic logic signed [31:0] sat32(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) begin
            return 32'sh7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            return 32'sh8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_FETCH;
            S_FETCH:  if (r_pair == LAST_PAIR) w_next_state = S_DRAIN1;
            S_DRAIN1: w_next_state = S_DRAIN2;
            S_DRAIN2: w_next_state = S_EMIT;
            S_EMIT:   w_next_state = (r_neuron == LAST_NEURON) ? S_DONE : S_FETCH;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Address generation: the weight address runs continuously across neurons,
    // the pixel address restarts at 0 for every neuron.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_waddr  <= '0;
            r_pair   <= '0;
            r_neuron <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_waddr  <= '0;
                    r_pair   <= '0;
                    r_neuron <= '0;
                end
                S_FETCH: begin
                    if (r_pair != LAST_PAIR) begin
                        r_waddr <= r_waddr + 12'd1;
                        r_pair  <= r_pair + 10'd1;
                    end
                end
                S_EMIT: begin
                    if (r_neuron != LAST_NEURON) begin
                        r_waddr  <= r_waddr + 12'd1;
                        r_pair   <= '0;
                        r_neuron <= r_neuron + 4'd1;
                    end
                end
                S_DONE: begin
                    r_waddr <= '0;
                    r_pair  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign weight_address = r_waddr;
    assign pixel_address1 = r_pair;
    assign pixel_address2 = r_pair;

    // p0: address issued; p1: SRAM data valid; p2: products registered.
    assign w_vld_p0 = (r_state == S_FETCH);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign w_pix0_p1  = $signed({1'b0, pixel_value1});
    assign w_pix1_p1  = $signed({1'b0, pixel_value2});
    assign w_wt0_p1   = $signed(weight_value[15:0]);
    assign w_wt1_p1   = $signed(weight_value[31:16]);
    assign w_prod0_p1 = 33'(w_pix0_p1) * 33'(w_wt0_p1);
    assign w_prod1_p1 = 33'(w_pix1_p1) * 33'(w_wt1_p1);

    always_ff @(posedge clk) begin
        if (r_vld_p1) begin
            r_prod0_p2 <= w_prod0_p1;
            r_prod1_p2 <= w_prod1_p1;
        end
    end

    // Clearing on entry to FETCH cannot collide with an accumulate: the pipeline
    // has already drained by EMIT.
    assign w_clear = (w_next_state == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_acc <= '0;
        end else if (w_clear) begin
            r_acc <= '0;
        end else if (r_vld_p2) begin
            r_acc <= r_acc + ACC_WIDTH'(r_prod0_p2) + ACC_WIDTH'(r_prod1_p2);
        end
    end

    assign w_sum_sat = sat32(r_acc);

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_max_sum <= '0;
            r_class   <= '0;
        end else if (r_state == S_EMIT) begin
            if ((r_neuron == 4'd0) || (w_sum_sat > r_max_sum)) begin
                r_max_sum <= w_sum_sat;
                r_class   <= r_neuron;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign sum_valid    = (r_state == S_EMIT);
    assign neuron_index = sum_valid ? r_neuron : 4'd0;
    assign neuron_sum   = sum_valid ? w_sum_sat : 32'sd0;
    assign class_out    = r_class;

endmodule
